// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares a combinational single-port ROM between fetch (I) and data (D) requesters; define ROM_ARB_RR_EN for round-robin instead of fixed D-over-I priority.
module rom_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int ROM_AW    = 11,
  parameter int ROM_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_data,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data
);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ROM_DEPTH * 4);
  logic        i_elig, d_elig, i_gnt, d_gnt, i_bad, d_bad;
  logic        i_full_q, i_full_d, d_full_q, d_full_d;
  logic        i_err_q, i_err_d, d_err_q, d_err_d;
  logic [31:0] i_data_q, i_data_d, d_data_q, d_data_d;
`ifdef ROM_ARB_RR_EN
  logic        rr_last_q, rr_last_d;
`endif
  always_comb begin
    i_bad = (|i_req_addr[1:0]) || (i_req_addr >= LIMIT);
    d_bad = (|d_req_addr[1:0]) || (d_req_addr >= LIMIT);
    i_elig = i_req_valid && (!i_full_q || i_rsp_ready);
    d_elig = d_req_valid && (!d_full_q || d_rsp_ready);
`ifdef ROM_ARB_RR_EN
    d_gnt = d_elig && (!i_elig || !rr_last_q);
`else
    d_gnt = d_elig;
`endif
    i_gnt = i_elig && !d_gnt;
`ifdef ROM_ARB_RR_EN
    rr_last_d = d_gnt ? 1'b1 : (i_gnt ? 1'b0 : rr_last_q);
`endif
    i_full_d = i_gnt || (i_full_q && !i_rsp_ready);
    d_full_d = d_gnt || (d_full_q && !d_rsp_ready);
    i_err_d = i_gnt ? i_bad : i_err_q;
    d_err_d = d_gnt ? d_bad : d_err_q;
    i_data_d = i_gnt ? (i_bad ? 32'h0 : rom_data) : i_data_q;
    d_data_d = d_gnt ? (d_bad ? 32'h0 : rom_data) : d_data_q;
  end
  assign i_req_ready = i_gnt && rst_n;
  assign d_req_ready = d_gnt && rst_n;
  assign rom_addr    = d_gnt ? d_req_addr[ROM_AW+1:2] : i_req_addr[ROM_AW+1:2];
  assign i_rsp_valid = i_full_q;
  assign i_rsp_data  = i_data_q;
  assign i_rsp_err   = i_err_q;
  assign d_rsp_valid = d_full_q;
  assign d_rsp_data  = d_data_q;
  assign d_rsp_err   = d_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_full_q <= 1'b0;
      d_full_q <= 1'b0;
      i_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      i_data_q <= 32'h0;
      d_data_q <= 32'h0;
    end else begin
      i_full_q <= i_full_d;
      d_full_q <= d_full_d;
      i_err_q  <= i_err_d;
      d_err_q  <= d_err_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
    end
  end
`ifdef ROM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= 1'b0;
    else rr_last_q <= rr_last_d;
  end
`endif
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and random traffic against a queue-based reference of the two-port ROM arbiter.
module tb_rom_port_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        i_req_valid = 0, i_req_ready, i_rsp_valid, i_rsp_ready = 1, i_rsp_err;
  logic        d_req_valid = 0, d_req_ready, d_rsp_valid, d_rsp_ready = 1, d_rsp_err;
  logic [31:0] i_req_addr = 0, d_req_addr = 0, i_rsp_data, d_rsp_data, rom_data;
  logic [10:0] rom_addr;
  logic [31:0] rom_mem [2048];
  logic [32:0] iq [$], dq [$];
  int          checks = 0, errors = 0, i_hs = 0;
  logic        i_acc, d_acc;
`ifdef ROM_ARB_RR_EN
  logic        rr_m = 0;
`endif
  always #5 clk = ~clk;
  assign rom_data = rom_mem[rom_addr];
  rom_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask
  function automatic logic [32:0] ref_rsp(input logic [31:0] a);
    return (a % 4 != 0 || a >= 2048 * 4) ? {1'b1, 32'h0} : {1'b0, rom_mem[a / 4]};
  endfunction
  always @(negedge clk) begin : mon
    logic ie, de, gi, gd;
    if (!rst_n) begin
      chk("rst_i_req_ready", i_req_ready, 0);
      chk("rst_d_req_ready", d_req_ready, 0);
      chk("rst_rsp_valid", {i_rsp_valid, d_rsp_valid}, 0);
      iq.delete();
      dq.delete();
`ifdef ROM_ARB_RR_EN
      rr_m = 0;
`endif
    end else begin
      chk("i_rsp_valid", i_rsp_valid, iq.size() != 0);
      chk("d_rsp_valid", d_rsp_valid, dq.size() != 0);
      if (i_rsp_valid && iq.size() != 0) chk("i_rsp", {i_rsp_err, i_rsp_data}, iq[0]);
      if (d_rsp_valid && dq.size() != 0) chk("d_rsp", {d_rsp_err, d_rsp_data}, dq[0]);
      ie = i_req_valid && (iq.size() == 0 || i_rsp_ready);
      de = d_req_valid && (dq.size() == 0 || d_rsp_ready);
`ifdef ROM_ARB_RR_EN
      gd = de && (!ie || !rr_m);
`else
      gd = de;
`endif
      gi = ie && !gd;
`ifdef ROM_ARB_RR_EN
      if (gd) rr_m = 1;
      else if (gi) rr_m = 0;
`endif
      chk("i_req_ready", i_req_ready, gi);
      chk("d_req_ready", d_req_ready, gd);
      if (!gi && !gd) chk("rom_addr_idle", rom_addr, i_req_addr[12:2]);
      if (i_rsp_valid && i_rsp_ready && iq.size() != 0) begin
        void'(iq.pop_front());
        i_hs++;
      end
      if (d_rsp_valid && d_rsp_ready && dq.size() != 0) void'(dq.pop_front());
      if (gi) iq.push_back(ref_rsp(i_req_addr));
      if (gd) dq.push_back(ref_rsp(d_req_addr));
    end
  end
  task automatic step();
    @(negedge clk);
    i_acc = i_req_valid && i_req_ready;
    d_acc = d_req_valid && d_req_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    i_req_valid = 0;
    d_req_valid = 0;
    i_rsp_ready = 1;
    d_rsp_ready = 1;
    repeat (n) step();
  endtask
  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 7);
    logic [31:0] a = {19'h0, 11'($urandom), 2'b00};
    return r < 6 ? a : (r == 6 ? a | 32'($urandom_range(1, 3)) : 32'h2000 + $urandom_range(0, 32'hFFFF));
  endfunction
  initial begin
    int snap;
    for (int k = 0; k < 2048; k++) rom_mem[k] = $urandom;
    rom_mem[2] = 32'h00500093;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(2);
    i_req_valid = 1; i_req_addr = 32'h8;
    step();
    chk("lone_accept", i_acc, 1);
    i_req_valid = 0;
    idle(2);
    i_req_valid = 1; i_req_addr = 32'h0;
    d_req_valid = 1; d_req_addr = 32'h4;
    step();
    chk("conflict_c0", {i_acc, d_acc}, 2'b01);
    d_req_valid = 0;
    step();
    chk("conflict_c1", {i_acc, d_acc}, 2'b10);
    idle(2);
    d_req_valid = 1; d_req_addr = 32'h2;
    step();
    d_req_valid = 0;
    i_req_valid = 1; i_req_addr = 32'h2000;
    step();
    idle(2);
    i_rsp_ready = 0;
    i_req_valid = 1; i_req_addr = 32'h10;
    step();
    i_req_addr = 32'h14;
    repeat (5) begin
      step();
      chk("bp_stall", i_acc, 0);
    end
    i_rsp_ready = 1;
    step();
    chk("bp_drain_accept", i_acc, 1);
    idle(3);
    snap = i_hs;
    i_req_valid = 1;
    for (int k = 0; k < 8; k++) begin
      i_req_addr = 32'(k * 4);
      step();
      chk("thru_accept", i_acc, 1);
    end
    i_req_valid = 0;
    step();
    chk("thru_count", 32'(i_hs - snap), 8);
    idle(2);
    i_rsp_ready = 0; d_rsp_ready = 0;
    i_req_valid = 1; i_req_addr = 32'h0;
    d_req_valid = 1; d_req_addr = 32'h4;
    step();
    d_req_valid = 0;
    step();
    i_req_valid = 0;
    step();
    chk("full_before_rst", {i_rsp_valid, d_rsp_valid}, 2'b11);
    rst_n = 0;
    i_req_valid = 1; d_req_valid = 1;
    #1 chk("async_rst_clear", {i_rsp_valid, d_rsp_valid}, 0);
    step();
    step();
    rst_n = 1;
    idle(2);
    for (int c = 0; c < 3000; c++) begin
      if (!(i_req_valid && !i_acc)) i_req_valid = $urandom_range(0, 2) != 0;
      if (!(d_req_valid && !d_acc)) d_req_valid = $urandom_range(0, 2) != 0;
      i_req_addr = rand_addr();
      d_req_addr = rand_addr();
      i_rsp_ready = $urandom_range(0, 3) != 0;
      d_rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
